// File: rtl/complex_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : complex_product_accumulator
//  Description : Sums a burst of packed signed complex products {re,im}
//                received on a valid/ready stream into widened per-half
//                accumulators, then presents the complex sum once on a
//                valid/ready output. A job is opened with start/len.
//  Revision    : 1.0 - initial release
// ============================================================================
module complex_product_accumulator #(
  parameter  int PROD_WIDTH = 64,
  parameter  int LEN_W      = 8,
  localparam int HALF       = PROD_WIDTH / 2,
  localparam int ACC_W      = HALF + LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PROD_WIDTH-1:0]  in_prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*ACC_W-1:0]     out_sum,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acc  = 2'd1;
  localparam logic [1:0] c_out  = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [LEN_W-1:0]        r_count;
  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic [2*ACC_W-1:0]      r_sum;
  logic                    r_done;

  logic                    w_beat;
  logic                    w_last_beat;
  logic signed [ACC_W-1:0] w_re_ext;
  logic signed [ACC_W-1:0] w_im_ext;
  logic signed [ACC_W-1:0] w_acc_re_nxt;
  logic signed [ACC_W-1:0] w_acc_im_nxt;

  // Each half is sign-extended by LEN_W bits, enough headroom for a
  // full-length burst of full-scale products.
  assign w_re_ext     = {{LEN_W{in_prod[PROD_WIDTH-1]}}, in_prod[PROD_WIDTH-1:HALF]};
  assign w_im_ext     = {{LEN_W{in_prod[HALF-1]}}, in_prod[HALF-1:0]};
  assign w_acc_re_nxt = r_acc_re + w_re_ext;
  assign w_acc_im_nxt = r_acc_im + w_im_ext;

  assign w_beat      = in_valid && in_ready;
  assign w_last_beat = w_beat && (r_count == LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (start) w_state_nxt = (len == '0) ? c_out : c_acc;
      c_acc:  if (w_last_beat) w_state_nxt = c_out;
      c_out:  if (out_ready) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Outputs decoded from state plus the registered datapath results
  always_comb begin
    in_ready  = (r_state == c_acc);
    out_valid = (r_state == c_out);
    busy      = (r_state != c_idle);
    done      = r_done;
    out_sum   = r_sum;
  end

  // Accumulators, beat counter, result register and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == c_out) && out_ready;
      if ((r_state == c_idle) && start) begin
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_count  <= len;
        // An empty job goes straight to OUT with a zero sum.
        if (len == '0) r_sum <= '0;
      end
      if (w_beat) begin
        r_acc_re <= w_acc_re_nxt;
        r_acc_im <= w_acc_im_nxt;
        r_count  <= r_count - LEN_W'(1);
      end
      // Capture the final sum including the last beat, so out_sum only
      // changes on the way into OUT and is stable while waiting there.
      if (w_last_beat) r_sum <= {w_acc_re_nxt, w_acc_im_nxt};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complex_product_accumulator
//  Description : Self-checking bench for complex_product_accumulator.
//                Expected sums come from a plain-arithmetic model over the
//                list of products sent in each job.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_product_accumulator;

  localparam int PW = 64;
  localparam int LW = 8;
  localparam int AW = 40;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   len;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_prod;
  logic            out_valid;
  logic            out_ready;
  logic [2*AW-1:0] out_sum;
  logic            busy;
  logic            done;

  int errors;
  int checks;

  logic [PW-1:0]   prod_q[$];

  logic [2*AW-1:0] obs_sum;
  int              obs_lat;
  bit              obs_timeout;
  bit              obs_stable;
  bit              obs_ready_seen;
  bit              obs_done_early;
  bit              obs_done1;
  bit              obs_busy_after;

  complex_product_accumulator #(.PROD_WIDTH(PW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PW-1:0] pack(input int re, input int im);
    return {re, im};
  endfunction

  // Reference: plain signed sums of the halves, truncated to the output width.
  function automatic logic [2*AW-1:0] model_sum();
    longint sre;
    longint sim;
    logic [63:0] ure;
    logic [63:0] uim;
    sre = 0;
    sim = 0;
    foreach (prod_q[i]) begin
      sre += longint'($signed(prod_q[i][63:32]));
      sim += longint'($signed(prod_q[i][31:0]));
    end
    ure = sre;
    uim = sim;
    return {ure[AW-1:0], uim[AW-1:0]};
  endfunction

  // Runs one job from the current (edge+1) point and ends in the cycle
  // right after the output handshake, with observations left in obs_*.
  task automatic drive_job(input int n, input int gap, input int hold, input bit poke);
    int idx;
    int gapc;
    int cyc;
    int last;
    logic [2*AW-1:0] first;
    idx = 0; gapc = 0; cyc = 0; last = 0;
    obs_timeout = 0; obs_stable = 1; obs_ready_seen = 0; obs_done_early = 0;
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = LW'(n + 3);
    while (idx < n && cyc < 4000) begin
      if (poke && idx == 1) begin
        start = 1'b1;
        len   = LW'(n + 7);
      end else begin
        start = 1'b0;
      end
      if (gapc > 0) begin
        in_valid = 1'b0;
        gapc--;
      end else begin
        in_valid = 1'b1;
        in_prod  = prod_q[idx];
      end
      if (in_ready) obs_ready_seen = 1;
      if (in_valid && in_ready) begin
        idx++;
        gapc = gap;
        last = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (idx < n) obs_timeout = 1;
    while (!out_valid && cyc < 4000) begin
      if (in_ready) obs_ready_seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) obs_timeout = 1;
    if (in_ready) obs_ready_seen = 1;
    if (done) obs_done_early = 1;
    obs_lat = cyc - last + 1;
    first   = out_sum;
    obs_sum = out_sum;
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || out_sum !== first) obs_stable = 0;
      if (in_ready) obs_ready_seen = 1;
      if (done) obs_done_early = 1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    obs_done1      = done;
    obs_busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, busy, done});
    end
    checks++;
    if (out_sum !== '0) begin
      errors++;
      $display("FAIL reset_sum: got %h expected 0", out_sum);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_sum !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: sum %h busy %b expected 0 0", out_sum, busy);
    end
  endtask

  task automatic test_basic();
    logic [2*AW-1:0] exp_c;
    exp_c = {40'sd10, -40'sd10};
    prod_q.delete();
    for (int i = 1; i <= 4; i++) prod_q.push_back(pack(i, -i));
    drive_job(4, 0, 0, 0);
    checks++;
    if (obs_timeout) begin errors++; $display("FAIL basic_timeout: job did not complete"); end
    checks++;
    if (obs_sum !== exp_c) begin
      errors++;
      $display("FAIL basic_sum: got %h expected %h", obs_sum, exp_c);
    end
    checks++;
    if (obs_lat !== 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 1", obs_lat);
    end
    checks++;
    if (obs_done1 !== 1'b1 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done %b busy %b expected 1 0", obs_done1, obs_busy_after);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done %b expected 0", done);
    end
  endtask

  task automatic test_len0();
    prod_q.delete();
    drive_job(0, 0, 1, 0);
    checks++;
    if (obs_timeout || obs_sum !== '0) begin
      errors++;
      $display("FAIL len0_sum: got %h (timeout %b) expected 0", obs_sum, obs_timeout);
    end
    checks++;
    if (obs_lat !== 1) begin
      errors++;
      $display("FAIL len0_latency: got %0d cycles after start edge expected 1", obs_lat);
    end
    checks++;
    if (obs_ready_seen) begin
      errors++;
      $display("FAIL len0_in_ready: got pulse expected none");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fullscale();
    logic [2*AW-1:0] exp_c;
    exp_c = {-40'sd547608330240, -40'sd547608330240};
    prod_q.delete();
    for (int i = 0; i < 255; i++) prod_q.push_back(64'h80000000_80000000);
    drive_job(255, 0, 0, 0);
    checks++;
    if (obs_timeout || obs_sum !== exp_c) begin
      errors++;
      $display("FAIL fullscale_sum: got %h expected %h (timeout %b)", obs_sum, exp_c, obs_timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stalls();
    logic [2*AW-1:0] exp_m;
    prod_q.delete();
    prod_q.push_back(pack(-100, 7));
    prod_q.push_back(pack(2000000000, -3));
    prod_q.push_back(pack(2000000000, 123456));
    exp_m = model_sum();
    drive_job(3, 2, 5, 0);
    checks++;
    if (obs_timeout || obs_sum !== exp_m) begin
      errors++;
      $display("FAIL stalls_sum: got %h expected %h (timeout %b)", obs_sum, exp_m, obs_timeout);
    end
    checks++;
    if (!obs_stable) begin
      errors++;
      $display("FAIL stalls_hold: out_valid/out_sum changed while out_ready low, expected stable");
    end
    checks++;
    if (obs_done_early || obs_done1 !== 1'b1) begin
      errors++;
      $display("FAIL stalls_done: early %b at_handshake %b expected 0 1", obs_done_early, obs_done1);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stalls_done_once: done %b expected 0", done);
    end
  endtask

  task automatic test_start_ignored();
    logic [2*AW-1:0] exp_m;
    prod_q.delete();
    for (int i = 0; i < 4; i++) prod_q.push_back({$urandom, $urandom});
    exp_m = model_sum();
    drive_job(4, 1, 0, 1);
    checks++;
    if (obs_timeout || obs_sum !== exp_m || obs_lat !== 1) begin
      errors++;
      $display("FAIL start_ignored: got %h lat %0d expected %h lat 1 (timeout %b)",
               obs_sum, obs_lat, exp_m, obs_timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2*AW-1:0] exp_a;
    logic [2*AW-1:0] exp_b;
    prod_q.delete();
    for (int i = 0; i < 5; i++) prod_q.push_back({$urandom, $urandom});
    exp_a = model_sum();
    drive_job(5, 0, 0, 0);
    checks++;
    if (obs_timeout || obs_sum !== exp_a) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", obs_sum, exp_a);
    end
    // Second job starts in the cycle done is high.
    prod_q.delete();
    for (int i = 0; i < 2; i++) prod_q.push_back({$urandom, $urandom});
    exp_b = model_sum();
    drive_job(2, 0, 0, 0);
    checks++;
    if (obs_timeout || obs_sum !== exp_b || obs_lat !== 1) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat 1", obs_sum, obs_lat, exp_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [2*AW-1:0] exp_c;
    exp_c = {40'sd5, 40'sd7};
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_prod  = pack(1000 + i, -2000 - i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_sum !== '0) begin
      errors++;
      $display("FAIL abort_outputs: flags %b sum %h expected 0000 0",
               {in_ready, out_valid, busy, done}, out_sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    prod_q.delete();
    prod_q.push_back(pack(5, 7));
    drive_job(1, 0, 0, 0);
    checks++;
    if (obs_timeout || obs_sum !== exp_c) begin
      errors++;
      $display("FAIL abort_next_job: got %h expected %h", obs_sum, exp_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n;
    logic [2*AW-1:0] exp_m;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 24);
      prod_q.delete();
      for (int i = 0; i < n; i++) prod_q.push_back({$urandom, $urandom});
      exp_m = model_sum();
      drive_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      checks++;
      if (obs_timeout || obs_sum !== exp_m || obs_lat !== 1 || !obs_stable || obs_done1 !== 1'b1) begin
        errors++;
        $display("FAIL random_job%0d: got %h lat %0d stable %b done %b expected %h lat 1 stable 1 done 1",
                 j, obs_sum, obs_lat, obs_stable, obs_done1, exp_m);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_fullscale();
    test_stalls();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
